// File: rtl/gb_lcd_frame_writer.sv
// Captures the PPU pixel stream into a front/back frame-buffer pair and blank-fills the back bank while the LCD is off.
// Define GB_FRAME_DOUBLE_BUFFER_EN for two banks; otherwise a single bank at address 0 is written in place.
module gb_lcd_frame_writer #(
    parameter int GB_W      = 160,
    parameter int GB_H      = 144,
    parameter int FRAME_PIX = GB_W * GB_H
) (
    input  logic        GameBoy_clk,
    input  logic        GameBoy_reset_n,
    input  logic [1:0]  LD,
    input  logic        PX_VALID,
    input  logic        LCD_VSYNC,
    input  logic        LCD_ON,
    input  logic        ERR_CLR,
    output logic [15:0] WR_ADDR,
    output logic [1:0]  WR_DATA,
    output logic        WR_EN,
    output logic        FRONT_BANK,
    output logic        FRAME_DONE,
    output logic [7:0]  FRAME_CNT,
    output logic        FRAME_ERR
);

    localparam logic [15:0] BANK1_BASE = 16'(FRAME_PIX);
    localparam logic [14:0] LAST_PIX   = 15'(FRAME_PIX - 1);

    typedef enum logic [1:0] {
        WAIT_SYNC,
        CAPTURE,
        BLANK_FILL,
        LCD_OFF
    } state_t;

    state_t      state;
    logic [14:0] pix_cnt;
    logic [15:0] back_base;
    logic [15:0] pix_addr;
    logic        last_capture;
    logic        last_fill;
    logic        publish_now;

    // The last pixel of a bank is written on the same edge the bank is published.
    assign last_capture = (state == CAPTURE) && LCD_ON && !LCD_VSYNC && PX_VALID
                          && (pix_cnt == LAST_PIX);
    assign last_fill    = (state == BLANK_FILL) && (pix_cnt == LAST_PIX);
    assign publish_now  = last_capture || last_fill;

    assign pix_addr = back_base + 16'(pix_cnt);

`ifdef GB_FRAME_DOUBLE_BUFFER_EN
    logic back_bank;

    always_ff @(posedge GameBoy_clk or negedge GameBoy_reset_n) begin
        if (!GameBoy_reset_n) begin
            back_bank  <= 1'b1;
            FRONT_BANK <= 1'b0;
        end else if (publish_now) begin
            FRONT_BANK <= back_bank;
            back_bank  <= ~back_bank;
        end
    end

    assign back_base = back_bank ? BANK1_BASE : 16'd0;
`else
    assign back_base  = 16'd0;
    assign FRONT_BANK = 1'b0;
`endif

    always_ff @(posedge GameBoy_clk or negedge GameBoy_reset_n) begin
        if (!GameBoy_reset_n) begin
            state      <= WAIT_SYNC;
            pix_cnt    <= 15'd0;
            WR_EN      <= 1'b0;
            WR_ADDR    <= 16'd0;
            WR_DATA    <= 2'b00;
            FRAME_DONE <= 1'b0;
            FRAME_CNT  <= 8'd0;
            FRAME_ERR  <= 1'b0;
        end else begin
            WR_EN      <= 1'b0;
            FRAME_DONE <= 1'b0;

            // Clear first so a same-cycle short-frame set below takes precedence.
            if (ERR_CLR)
                FRAME_ERR <= 1'b0;

            if (publish_now) begin
                FRAME_DONE <= 1'b1;
                FRAME_CNT  <= FRAME_CNT + 8'd1;
            end

            case (state)
                WAIT_SYNC: begin
                    if (!LCD_ON) begin
                        state   <= BLANK_FILL;
                        pix_cnt <= 15'd0;
                    end else if (LCD_VSYNC) begin
                        state <= CAPTURE;
                        if (PX_VALID) begin
                            WR_EN   <= 1'b1;
                            WR_ADDR <= back_base;
                            WR_DATA <= LD;
                            pix_cnt <= 15'd1;
                        end else begin
                            pix_cnt <= 15'd0;
                        end
                    end
                end

                CAPTURE: begin
                    if (!LCD_ON) begin
                        state   <= BLANK_FILL;
                        pix_cnt <= 15'd0;
                    end else if (LCD_VSYNC) begin
                        if (pix_cnt != 15'd0)
                            FRAME_ERR <= 1'b1;
                        if (PX_VALID) begin
                            WR_EN   <= 1'b1;
                            WR_ADDR <= back_base;
                            WR_DATA <= LD;
                            pix_cnt <= 15'd1;
                        end else begin
                            pix_cnt <= 15'd0;
                        end
                    end else if (PX_VALID) begin
                        WR_EN   <= 1'b1;
                        WR_ADDR <= pix_addr;
                        WR_DATA <= LD;
                        if (last_capture) begin
                            pix_cnt <= 15'd0;
                            state   <= WAIT_SYNC;
                        end else begin
                            pix_cnt <= pix_cnt + 15'd1;
                        end
                    end
                end

                BLANK_FILL: begin
                    WR_EN   <= 1'b1;
                    WR_ADDR <= pix_addr;
                    WR_DATA <= 2'b00;
                    if (last_fill) begin
                        pix_cnt <= 15'd0;
                        state   <= LCD_OFF;
                    end else begin
                        pix_cnt <= pix_cnt + 15'd1;
                    end
                end

                LCD_OFF: begin
                    if (LCD_ON)
                        state <= WAIT_SYNC;
                end

                default: state <= WAIT_SYNC;
            endcase
        end
    end

endmodule

// File: tb/tb_gb_lcd_frame_writer.sv
// Directed bench for gb_lcd_frame_writer: full frames, short frames, LCD-off blank fill, mid-frame reset.
module tb_gb_lcd_frame_writer;

`ifdef GB_FRAME_DOUBLE_BUFFER_EN
    localparam bit DB = 1'b1;
`else
    localparam bit DB = 1'b0;
`endif
    localparam int FP = 23040;

    logic        GameBoy_clk;
    logic        GameBoy_reset_n;
    logic [1:0]  LD;
    logic        PX_VALID;
    logic        LCD_VSYNC;
    logic        LCD_ON;
    logic        ERR_CLR;
    logic [15:0] WR_ADDR;
    logic [1:0]  WR_DATA;
    logic        WR_EN;
    logic        FRONT_BANK;
    logic        FRAME_DONE;
    logic [7:0]  FRAME_CNT;
    logic        FRAME_ERR;

    int  checks = 0;
    int  errors = 0;
    bit  exp_back = 1'b1;
    int  exp_cnt = 0;

    gb_lcd_frame_writer dut (
        .GameBoy_clk     (GameBoy_clk),
        .GameBoy_reset_n (GameBoy_reset_n),
        .LD              (LD),
        .PX_VALID        (PX_VALID),
        .LCD_VSYNC       (LCD_VSYNC),
        .LCD_ON          (LCD_ON),
        .ERR_CLR         (ERR_CLR),
        .WR_ADDR         (WR_ADDR),
        .WR_DATA         (WR_DATA),
        .WR_EN           (WR_EN),
        .FRONT_BANK      (FRONT_BANK),
        .FRAME_DONE      (FRAME_DONE),
        .FRAME_CNT       (FRAME_CNT),
        .FRAME_ERR       (FRAME_ERR)
    );

    initial begin
        GameBoy_clk = 1'b0;
        forever #5 GameBoy_clk = ~GameBoy_clk;
    end

    initial begin
        #5_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    function automatic int base_of(input bit b);
        return (DB && b) ? FP : 0;
    endfunction

    function automatic bit front_of(input bit b);
        return DB ? b : 1'b0;
    endfunction

    task automatic step();
        @(posedge GameBoy_clk);
        #1;
    endtask

    task automatic drive_idle();
        PX_VALID  = 1'b0;
        LCD_VSYNC = 1'b0;
        ERR_CLR   = 1'b0;
        LD        = 2'b00;
    endtask

    task automatic test_reset();
        GameBoy_reset_n = 1'b0;
        LCD_ON = 1'b1;
        drive_idle();
        step();
        step();
        checks++;
        if (WR_EN !== 1'b0 || WR_ADDR !== 16'd0 || WR_DATA !== 2'd0 || FRAME_DONE !== 1'b0
            || FRAME_CNT !== 8'd0 || FRAME_ERR !== 1'b0 || FRONT_BANK !== 1'b0) begin
            errors++;
            $display("FAIL reset_values: en=%b addr=%0d data=%0d done=%b cnt=%0d err=%b front=%b, required all 0",
                     WR_EN, WR_ADDR, WR_DATA, FRAME_DONE, FRAME_CNT, FRAME_ERR, FRONT_BANK);
        end
        GameBoy_reset_n = 1'b1;
        step();
    endtask

    task automatic test_full_frame(input string tag);
        int base;
        int bad_wr;
        int bad_done;
        int bad_front;
        bit front_before;
        base = base_of(exp_back);
        bad_wr = 0;
        bad_done = 0;
        bad_front = 0;
        front_before = FRONT_BANK;
        for (int i = 0; i < FP; i++) begin
            LCD_VSYNC = (i == 0);
            PX_VALID  = 1'b1;
            LD        = 2'(i);
            step();
            if (WR_EN !== 1'b1 || WR_ADDR !== 16'(base + i) || WR_DATA !== 2'(i)) begin
                if (bad_wr == 0)
                    $display("  first bad write %s at pixel %0d: en=%b addr=%0d data=%0d", tag, i, WR_EN, WR_ADDR, WR_DATA);
                bad_wr++;
            end
            if (FRAME_DONE !== (i == FP - 1))
                bad_done++;
            if (i < FP - 1 && FRONT_BANK !== front_before)
                bad_front++;
        end
        drive_idle();
        checks++;
        if (bad_wr != 0) begin
            errors++;
            $display("FAIL %s_writes: %0d bad writes, required 0 (base %0d)", tag, bad_wr, base);
        end
        checks++;
        if (bad_done != 0) begin
            errors++;
            $display("FAIL %s_frame_done: %0d misplaced FRAME_DONE cycles, required 0", tag, bad_done);
        end
        checks++;
        if (bad_front != 0) begin
            errors++;
            $display("FAIL %s_front_stable: FRONT_BANK moved %0d times before publish, required 0", tag, bad_front);
        end
        exp_cnt++;
        checks++;
        if (FRONT_BANK !== front_of(exp_back) || FRAME_CNT !== 8'(exp_cnt)) begin
            errors++;
            $display("FAIL %s_publish: front=%b cnt=%0d, required front=%b cnt=%0d",
                     tag, FRONT_BANK, FRAME_CNT, front_of(exp_back), exp_cnt);
        end
        exp_back = ~exp_back;
        step();
        checks++;
        if (FRAME_DONE !== 1'b0 || WR_EN !== 1'b0) begin
            errors++;
            $display("FAIL %s_after_publish: done=%b en=%b, required 0 0", tag, FRAME_DONE, WR_EN);
        end
    endtask

    task automatic test_no_write_before_sync();
        int wr_seen;
        wr_seen = 0;
        for (int i = 0; i < 10; i++) begin
            PX_VALID = 1'b1;
            LD = 2'd3;
            step();
            if (WR_EN === 1'b1)
                wr_seen++;
        end
        drive_idle();
        checks++;
        if (wr_seen != 0) begin
            errors++;
            $display("FAIL no_write_before_sync: %0d writes, required 0", wr_seen);
        end
    endtask

    task automatic test_short_frame();
        int base;
        int bad_wr;
        int done_seen;
        base = base_of(exp_back);
        bad_wr = 0;
        done_seen = 0;
        for (int i = 0; i < 5000; i++) begin
            LCD_VSYNC = (i == 0);
            PX_VALID  = 1'b1;
            LD        = 2'(i);
            step();
            if (WR_EN !== 1'b1 || WR_ADDR !== 16'(base + i))
                bad_wr++;
            if (FRAME_DONE === 1'b1)
                done_seen++;
        end
        checks++;
        if (bad_wr != 0) begin
            errors++;
            $display("FAIL short_prefix_writes: %0d bad writes, required 0", bad_wr);
        end
        // VSYNC alone after 5000 pixels
        LCD_VSYNC = 1'b1; PX_VALID = 1'b0;
        step();
        if (FRAME_DONE === 1'b1) done_seen++;
        checks++;
        if (FRAME_ERR !== 1'b1 || WR_EN !== 1'b0) begin
            errors++;
            $display("FAIL short_err_set: err=%b en=%b, required err=1 en=0", FRAME_ERR, WR_EN);
        end
        LCD_VSYNC = 1'b0; PX_VALID = 1'b1; LD = 2'd3;
        step();
        if (FRAME_DONE === 1'b1) done_seen++;
        checks++;
        if (WR_EN !== 1'b1 || WR_ADDR !== 16'(base) || WR_DATA !== 2'd3) begin
            errors++;
            $display("FAIL short_restart_addr: en=%b addr=%0d data=%0d, required en=1 addr=%0d data=3",
                     WR_EN, WR_ADDR, WR_DATA, base);
        end
        PX_VALID = 1'b0; ERR_CLR = 1'b1;
        step();
        ERR_CLR = 1'b0;
        checks++;
        if (FRAME_ERR !== 1'b0) begin
            errors++;
            $display("FAIL err_clr: err=%b, required 0", FRAME_ERR);
        end
        // VSYNC with PX_VALID at pix_cnt=1: new pixel 0 plus short-frame error
        LCD_VSYNC = 1'b1; PX_VALID = 1'b1; LD = 2'd2;
        step();
        if (FRAME_DONE === 1'b1) done_seen++;
        checks++;
        if (FRAME_ERR !== 1'b1 || WR_EN !== 1'b1 || WR_ADDR !== 16'(base) || WR_DATA !== 2'd2) begin
            errors++;
            $display("FAIL vsync_px_same_cycle: err=%b en=%b addr=%0d data=%0d, required err=1 en=1 addr=%0d data=2",
                     FRAME_ERR, WR_EN, WR_ADDR, WR_DATA, base);
        end
        LCD_VSYNC = 1'b1; PX_VALID = 1'b0; ERR_CLR = 1'b1;
        step();
        checks++;
        if (FRAME_ERR !== 1'b1) begin
            errors++;
            $display("FAIL err_set_wins: err=%b, required 1", FRAME_ERR);
        end
        LCD_VSYNC = 1'b0;
        step();
        ERR_CLR = 1'b0;
        checks++;
        if (FRAME_ERR !== 1'b0 || done_seen != 0 || FRAME_CNT !== 8'(exp_cnt)) begin
            errors++;
            $display("FAIL short_no_publish: err=%b done_pulses=%0d cnt=%0d, required err=0 pulses=0 cnt=%0d",
                     FRAME_ERR, done_seen, FRAME_CNT, exp_cnt);
        end
    endtask

    task automatic test_reset_mid_frame();
        int wr_seen;
        wr_seen = 0;
        for (int i = 0; i < 12000; i++) begin
            LCD_VSYNC = (i == 0);
            PX_VALID  = 1'b1;
            LD        = 2'(i);
            step();
        end
        #2;
        GameBoy_reset_n = 1'b0;
        #1;
        checks++;
        if (WR_EN !== 1'b0 || WR_ADDR !== 16'd0 || WR_DATA !== 2'd0 || FRAME_DONE !== 1'b0
            || FRAME_CNT !== 8'd0 || FRAME_ERR !== 1'b0 || FRONT_BANK !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: en=%b addr=%0d data=%0d done=%b cnt=%0d err=%b front=%b, required all 0",
                     WR_EN, WR_ADDR, WR_DATA, FRAME_DONE, FRAME_CNT, FRAME_ERR, FRONT_BANK);
        end
        drive_idle();
        step();
        step();
        GameBoy_reset_n = 1'b1;
        exp_back = 1'b1;
        exp_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            PX_VALID = 1'b1;
            step();
            if (WR_EN === 1'b1)
                wr_seen++;
        end
        drive_idle();
        checks++;
        if (wr_seen != 0) begin
            errors++;
            $display("FAIL reset_needs_vsync: %0d writes, required 0", wr_seen);
        end
    endtask

    task automatic test_lcd_off_fill();
        int base;
        int bad_wr;
        int bad_done;
        int wr_seen;
        base = base_of(exp_back);
        bad_wr = 0;
        bad_done = 0;
        wr_seen = 0;
        for (int i = 0; i < 10; i++) begin
            LCD_VSYNC = (i == 0);
            PX_VALID  = 1'b1;
            LD        = 2'd1;
            step();
        end
        checks++;
        if (WR_EN !== 1'b1 || WR_ADDR !== 16'(base + 9)) begin
            errors++;
            $display("FAIL pre_off_capture: en=%b addr=%0d, required en=1 addr=%0d", WR_EN, WR_ADDR, base + 9);
        end
        LCD_VSYNC = 1'b0; LCD_ON = 1'b0; PX_VALID = 1'b1; LD = 2'd3;
        step();
        checks++;
        if (WR_EN !== 1'b0) begin
            errors++;
            $display("FAIL lcd_off_entry: en=%b, required 0", WR_EN);
        end
        for (int k = 0; k < FP; k++) begin
            LCD_VSYNC = (k == 5000);
            LCD_ON    = (k >= 20000 && k < 22000);
            step();
            if (WR_EN !== 1'b1 || WR_ADDR !== 16'(base + k) || WR_DATA !== 2'd0) begin
                if (bad_wr == 0)
                    $display("  first bad fill write at %0d: en=%b addr=%0d data=%0d", k, WR_EN, WR_ADDR, WR_DATA);
                bad_wr++;
            end
            if (FRAME_DONE !== (k == FP - 1))
                bad_done++;
        end
        checks++;
        if (bad_wr != 0) begin
            errors++;
            $display("FAIL blank_fill_writes: %0d bad writes, required 0 (base %0d)", bad_wr, base);
        end
        checks++;
        if (bad_done != 0) begin
            errors++;
            $display("FAIL blank_fill_done: %0d misplaced FRAME_DONE cycles, required 0", bad_done);
        end
        exp_cnt++;
        checks++;
        if (FRONT_BANK !== front_of(exp_back) || FRAME_CNT !== 8'(exp_cnt)) begin
            errors++;
            $display("FAIL blank_fill_publish: front=%b cnt=%0d, required front=%b cnt=%0d",
                     FRONT_BANK, FRAME_CNT, front_of(exp_back), exp_cnt);
        end
        exp_back = ~exp_back;
        for (int i = 0; i < 20; i++) begin
            LCD_VSYNC = (i % 5 == 0);
            PX_VALID  = 1'b1;
            step();
            if (WR_EN === 1'b1)
                wr_seen++;
        end
        LCD_ON = 1'b1; LCD_VSYNC = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            if (WR_EN === 1'b1)
                wr_seen++;
        end
        checks++;
        if (wr_seen != 0) begin
            errors++;
            $display("FAIL lcd_off_no_writes: %0d writes, required 0", wr_seen);
        end
        LCD_VSYNC = 1'b1; PX_VALID = 1'b1; LD = 2'd1;
        step();
        drive_idle();
        checks++;
        if (WR_EN !== 1'b1 || WR_ADDR !== 16'(base_of(exp_back)) || WR_DATA !== 2'd1) begin
            errors++;
            $display("FAIL resume_capture: en=%b addr=%0d data=%0d, required en=1 addr=%0d data=1",
                     WR_EN, WR_ADDR, WR_DATA, base_of(exp_back));
        end
    endtask

    initial begin
        GameBoy_reset_n = 1'b0;
        LCD_ON = 1'b1;
        drive_idle();
        test_reset();
        test_full_frame("frame1");
        test_no_write_before_sync();
        test_full_frame("frame2");
        test_short_frame();
        test_reset_mid_frame();
        test_lcd_off_fill();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
